// File: rtl/rs_chien_search.sv
// Chien search for RS(255,239): evaluates the latched error-locator at alpha^k, k = 0..254,
// and streams one error position per root. Optional macro CHIEN_EARLY_STOP_EN ends the scan once deg roots are found.
module rs_chien_search (
    input  logic       clk,
    input  logic       reset,
    input  logic       L_ready,
    input  logic [7:0] L1,
    input  logic [7:0] L2,
    input  logic [7:0] L3,
    input  logic [7:0] L4,
    input  logic [7:0] L5,
    input  logic [7:0] L6,
    input  logic [7:0] L7,
    input  logic [7:0] L8,
    output logic       loc_valid,
    output logic [7:0] loc,
    output logic [7:0] lam_odd,
    output logic       done,
    output logic [3:0] root_cnt,
    output logic       fail,
    output logic       busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    // alpha^j for j = 1..8 in the 0x11D field
    localparam logic [7:0] ALPHA_POW [1:8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1D};

    // Multiplication mod 0x11D; with a constant operand this folds into a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    state_t     state, state_next;
    logic [7:0] r    [1:8];
    logic [7:0] l_in [1:8];
    logic [7:0] k;
    logic [3:0] deg, deg_in;
    logic [7:0] sum, odd;
    logic       is_root, last_eval;
    logic [3:0] cnt_next;

    // NOTE: every signal written in always_comb gets a default before any branch, so no latch is inferred.
    always_comb begin
        l_in[1] = L1; l_in[2] = L2; l_in[3] = L3; l_in[4] = L4;
        l_in[5] = L5; l_in[6] = L6; l_in[7] = L7; l_in[8] = L8;
        deg_in = 4'd0;
        for (int j = 1; j <= 8; j++) begin
            if (l_in[j] != 8'd0) deg_in = 4'(j);
        end
    end

    always_comb begin
        sum = 8'h01;
        for (int j = 1; j <= 8; j++) sum = sum ^ r[j];
        odd      = r[1] ^ r[3] ^ r[5] ^ r[7];
        is_root  = (sum == 8'h00);
        cnt_next = root_cnt + {3'b000, (is_root && root_cnt != 4'd8)};
`ifdef CHIEN_EARLY_STOP_EN
        last_eval = (k == 8'd254) || (cnt_next == deg);
`else
        last_eval = (k == 8'd254);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (L_ready)   state_next = SCAN;
            SCAN:    if (last_eval) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 1; j <= 8; j++) r[j] <= 8'h00;
            k         <= 8'd0;
            deg       <= 4'd0;
            loc_valid <= 1'b0;
            loc       <= 8'd0;
            lam_odd   <= 8'd0;
            done      <= 1'b0;
            root_cnt  <= 4'd0;
            fail      <= 1'b0;
        end else begin
            loc_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (L_ready) begin
                        for (int j = 1; j <= 8; j++) r[j] <= l_in[j];
                        deg      <= deg_in;
                        k        <= 8'd0;
                        root_cnt <= 4'd0;
                        fail     <= 1'b0;
                    end
                end
                SCAN: begin
                    for (int j = 1; j <= 8; j++) r[j] <= gf_mul(r[j], ALPHA_POW[j]);
                    k        <= k + 8'd1;
                    root_cnt <= cnt_next;
                    if (is_root) begin
                        loc_valid <= 1'b1;
                        loc       <= (k == 8'd0) ? 8'd0 : 8'd255 - k;
                        lam_odd   <= odd;
                    end
                    if (last_eval) begin
                        done <= 1'b1;
                        fail <= (cnt_next != deg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_rs_chien_search.sv
// Testbench for rs_chien_search: log/antilog model of the locator evaluation, per-cycle compare,
// and directed vectors with hand-computed positions and timings.
module tb_rs_chien_search;

    logic       clk = 1'b0;
    logic       reset;
    logic       L_ready;
    logic [7:0] L [1:8];
    logic       loc_valid, done, fail, busy;
    logic [7:0] loc, lam_odd;
    logic [3:0] root_cnt;

`ifdef CHIEN_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    rs_chien_search dut (
        .clk(clk), .reset(reset), .L_ready(L_ready),
        .L1(L[1]), .L2(L[2]), .L3(L[3]), .L4(L[4]),
        .L5(L[5]), .L6(L[6]), .L7(L[7]), .L8(L[8]),
        .loc_valid(loc_valid), .loc(loc), .lam_odd(lam_odd), .done(done),
        .root_cnt(root_cnt), .fail(fail), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Field tables built from repeated doubling mod 0x11D
    logic [7:0] gexp [0:254];
    int         glog [0:255];

    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // Model of one search: which k are reported, odd-term sums, end index and final counts
    logic [7:0] mL [1:8];
    bit         m_root [0:254];
    logic [7:0] m_odd  [0:254];
    int         m_end, m_cnt, m_deg;
    bit         m_fail;

    task automatic build_model();
        logic [7:0] val, odd, t;
        int         cnt;
        bit         stopped;
        m_deg = 0;
        for (int j = 1; j <= 8; j++) if (mL[j] != 8'd0) m_deg = j;
        cnt = 0; stopped = 0; m_end = 254;
        for (int kk = 0; kk < 255; kk++) begin
            m_root[kk] = 1'b0;
            m_odd[kk]  = 8'd0;
            if (!stopped) begin
                val = 8'h01; odd = 8'h00;
                for (int j = 1; j <= 8; j++) begin
                    t = fmul(mL[j], gexp[(j * kk) % 255]);
                    val ^= t;
                    if (j % 2 == 1) odd ^= t;
                end
                if (val == 8'd0) begin
                    m_root[kk] = 1'b1;
                    m_odd[kk]  = odd;
                    if (cnt < 8) cnt++;
                end
                if (EARLY && cnt == m_deg) begin
                    m_end = kk;
                    stopped = 1;
                end
            end
        end
        m_cnt  = cnt;
        m_fail = (cnt != m_deg);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    int e0 = 0;
    bit armed = 0;
    int lv_n, lv_cnt, done_n;
    logic [7:0] lv_loc;

    // Compare process: cycle following edge E0+n is checked at the negedge where cyc - e0 == n
    always @(negedge clk) begin
        int n, kk;
        bit ev;
        if (armed) begin
            n = cyc - e0;
            kk = n - 1;
            if (n == 0) begin
                check("loc_valid_n0", loc_valid, 0);
                check("busy_n0", busy, 1);
            end else if (n > 0) begin
                ev = (kk <= m_end) ? m_root[kk] : 1'b0;
                check("loc_valid", loc_valid, ev);
                if (ev) begin
                    check("loc", loc, (255 - kk) % 255);
                    check("lam_odd", lam_odd, m_odd[kk]);
                end
                check("done", done, kk == m_end);
                check("busy", busy, n <= m_end);
                if (kk >= m_end) begin
                    check("root_cnt", root_cnt, m_cnt);
                    check("fail", fail, m_fail);
                end
                if (loc_valid) begin
                    lv_n = n; lv_loc = loc; lv_cnt++;
                end
                if (done) done_n = n;
            end
        end
    end

    task automatic set_l(input logic [7:0] a1, input logic [7:0] a2);
        for (int j = 1; j <= 8; j++) mL[j] = 8'd0;
        mL[1] = a1; mL[2] = a2;
    endtask

    // Launch one search from mL; optionally pulse L_ready again at E0+100
    task automatic run(input bit second_pulse);
        build_model();
        lv_n = -1; lv_cnt = 0; done_n = -1; lv_loc = 8'hxx;
        @(negedge clk);
        for (int j = 1; j <= 8; j++) L[j] = mL[j];
        L_ready = 1'b1;
        e0 = cyc + 1;
        armed = 1'b1;
        for (int i = 0; i < m_end + 5; i++) begin
            @(negedge clk);
            L_ready = 1'b0;
            if (second_pulse && (cyc - e0) == 99) begin
                L_ready = 1'b1;
                L[1] = 8'h55; L[3] = 8'h9A;
            end
        end
        armed = 1'b0;
        L_ready = 1'b0;
    endtask

    initial begin
        int x, dcount;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = 8'(x);
            glog[x] = i;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11D;
        end
        glog[0] = 0;

        reset = 1'b1; L_ready = 1'b0;
        for (int j = 1; j <= 8; j++) L[j] = 8'd0;
        #1;
        check("rst_loc_valid", loc_valid, 0);
        check("rst_loc", loc, 0);
        check("rst_lam_odd", lam_odd, 0);
        check("rst_done", done, 0);
        check("rst_root_cnt", root_cnt, 0);
        check("rst_fail", fail, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single error alpha^5: pin the model, then the DUT
        set_l(8'h20, 8'h00);
        build_model();
        check("model_t1_cnt", m_cnt, 1);
        check("model_t1_root250", m_root[250], 1);
        check("model_t1_odd250", m_odd[250], 8'h01);
        run(0);
        check("t1_loc", lv_loc, 5);
        check("t1_loc_cycle", lv_n, 251);
        check("t1_done_cycle", done_n, EARLY ? 251 : 255);
        check("t1_root_cnt", root_cnt, 1);
        check("t1_fail", fail, 0);

        // Two errors at positions 10 and 3, with an ignored L_ready at E0+100
        set_l(8'h7C, 8'h87);
        build_model();
        check("model_t2_root245", m_root[245], 1);
        check("model_t2_root252", m_root[252], 1);
        run(1);
        check("t2_count", lv_cnt, 2);
        check("t2_last_loc", lv_loc, 3);
        check("t2_last_cycle", lv_n, 253);
        check("t2_root_cnt", root_cnt, 2);
        check("t2_fail", fail, 0);

        // Repeated root 1 + x^2
        set_l(8'h00, 8'h01);
        run(0);
        check("t3_count", lv_cnt, 1);
        check("t3_loc", lv_loc, 0);
        check("t3_loc_cycle", lv_n, 1);
        check("t3_done_cycle", done_n, 255);
        check("t3_root_cnt", root_cnt, 1);
        check("t3_fail", fail, 1);

        // All-zero locator
        set_l(8'h00, 8'h00);
        run(0);
        check("t4_count", lv_cnt, 0);
        check("t4_done_cycle", done_n, EARLY ? 1 : 255);
        check("t4_root_cnt", root_cnt, 0);
        check("t4_fail", fail, 0);

        // Reset at E0+50 aborts; no done afterwards; then a fresh run
        @(negedge clk);
        L[1] = 8'h7C; L[2] = 8'h87;
        L_ready = 1'b1;
        @(negedge clk);
        L_ready = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_loc_valid", loc_valid, 0);
        check("abort_loc", loc, 0);
        check("abort_lam_odd", lam_odd, 0);
        check("abort_root_cnt", root_cnt, 0);
        check("abort_fail", fail, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || loc_valid || busy) dcount++;
        end
        check("abort_no_activity", dcount, 0);

        set_l(8'h20, 8'h00);
        run(0);
        check("t5_loc", lv_loc, 5);
        check("t5_loc_cycle", lv_n, 251);
        check("t5_root_cnt", root_cnt, 1);
        check("t5_fail", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
